// File: rtl/regfile_2w2r_sb.sv
// Register file with two combinational read ports, two synchronous write
// ports, optional write-to-read bypass and a per-register busy scoreboard.
// Decode reads operands and locks destinations; writeback writes results and
// releases the matching busy bits.
module regfile_2w2r_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rbusy1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              rbusy2,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_addr,
  input  logic              flush,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] rf [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              wr0_ok;
  logic              wr1_ok;
  logic              hit1_w0, hit1_w1;
  logic              hit2_w0, hit2_w1;

  assign wr0_ok = we0 && !(ZERO_REG && (waddr0 == '0));
  assign wr1_ok = we1 && !(ZERO_REG && (waddr1 == '0));

  // Register array: port 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else begin
      if (wr0_ok) rf[waddr0] <= wdata0;
      if (wr1_ok) rf[waddr1] <= wdata1;
    end
  end

  // Next busy vector: writes clear, a lock sets (and beats a same-cycle
  // clear), flush drops everything including a simultaneous lock.
  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_nxt[i] = (busy[i] && !((we0 && (waddr0 == ADDR_W'(i))) ||
                                  (we1 && (waddr1 == ADDR_W'(i)))))
                    || (lock_en && (lock_addr == ADDR_W'(i)));
    end
    if (flush) busy_nxt = '0;
    if (ZERO_REG) busy_nxt[0] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
    end
  end

  // Busy bits and their population count update on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // Read port 1: zero register, then port 1 bypass, then port 0 bypass.
  always_comb begin
    hit1_w0 = we0 && (waddr0 == raddr1);
    hit1_w1 = we1 && (waddr1 == raddr1);
    rdata1  = rf[raddr1];
    if (BYPASS && hit1_w0) rdata1 = wdata0;
    if (BYPASS && hit1_w1) rdata1 = wdata1;
    rbusy1 = busy[raddr1] && !(BYPASS && (hit1_w0 || hit1_w1));
    if (ZERO_REG && (raddr1 == '0)) begin
      rdata1 = '0;
      rbusy1 = 1'b0;
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    hit2_w0 = we0 && (waddr0 == raddr2);
    hit2_w1 = we1 && (waddr1 == raddr2);
    rdata2  = rf[raddr2];
    if (BYPASS && hit2_w0) rdata2 = wdata0;
    if (BYPASS && hit2_w1) rdata2 = wdata1;
    rbusy2 = busy[raddr2] && !(BYPASS && (hit2_w0 || hit2_w1));
    if (ZERO_REG && (raddr2 == '0)) begin
      rdata2 = '0;
      rbusy2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Bench for regfile_2w2r_sb: a bypassing and a non-bypassing instance share
// the same stimulus and are compared against an array/flag reference model.
module tb_regfile_2w2r_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] raddr1, raddr2, waddr0, waddr1, lock_addr;
  logic [DW-1:0] wdata0, wdata1;
  logic          we0, we1, lock_en, flush;

  logic [DW-1:0] rdata1_b, rdata2_b, rdata1_n, rdata2_n;
  logic          rbusy1_b, rbusy2_b, rbusy1_n, rbusy2_n;
  logic [AW:0]   busy_cnt_b, busy_cnt_n;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem [N];
  bit            bsy [N];

  always #5 clk = ~clk;

  regfile_2w2r_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_b (
    .clk(clk), .reset(reset),
    .raddr1(raddr1), .rdata1(rdata1_b), .rbusy1(rbusy1_b),
    .raddr2(raddr2), .rdata2(rdata2_b), .rbusy2(rbusy2_b),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .lock_en(lock_en), .lock_addr(lock_addr), .flush(flush),
    .busy_cnt(busy_cnt_b)
  );

  regfile_2w2r_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_n (
    .clk(clk), .reset(reset),
    .raddr1(raddr1), .rdata1(rdata1_n), .rbusy1(rbusy1_n),
    .raddr2(raddr2), .rdata2(rdata2_n), .rbusy2(rbusy2_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .lock_en(lock_en), .lock_addr(lock_addr), .flush(flush),
    .busy_cnt(busy_cnt_n)
  );

  function automatic logic [DW-1:0] exp_rd(logic [AW-1:0] a, bit byp);
    if (a == 0) return '0;
    if (byp && we1 && waddr1 == a) return wdata1;
    if (byp && we0 && waddr0 == a) return wdata0;
    return mem[a];
  endfunction

  function automatic bit exp_busy(logic [AW-1:0] a, bit byp);
    bit hit;
    if (a == 0) return 1'b0;
    hit = (we0 && waddr0 == a) || (we1 && waddr1 == a);
    return bsy[a] && !(byp && hit);
  endfunction

  function automatic int exp_cnt();
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(bsy[i]);
    return s;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rdata1_byp", 64'(rdata1_b), 64'(exp_rd(raddr1, 1'b1)));
    chk("rdata2_byp", 64'(rdata2_b), 64'(exp_rd(raddr2, 1'b1)));
    chk("rbusy1_byp", 64'(rbusy1_b), 64'(exp_busy(raddr1, 1'b1)));
    chk("rbusy2_byp", 64'(rbusy2_b), 64'(exp_busy(raddr2, 1'b1)));
    chk("busy_cnt_byp", 64'(busy_cnt_b), 64'(exp_cnt()));
    chk("rdata1_nobyp", 64'(rdata1_n), 64'(exp_rd(raddr1, 1'b0)));
    chk("rdata2_nobyp", 64'(rdata2_n), 64'(exp_rd(raddr2, 1'b0)));
    chk("rbusy1_nobyp", 64'(rbusy1_n), 64'(exp_busy(raddr1, 1'b0)));
    chk("rbusy2_nobyp", 64'(rbusy2_n), 64'(exp_busy(raddr2, 1'b0)));
    chk("busy_cnt_nobyp", 64'(busy_cnt_n), 64'(exp_cnt()));
  endtask

  // Reference behaviour at a clock edge, using the inputs held for that edge.
  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mem[i] = '0;
        bsy[i] = 1'b0;
      end
    end else begin
      if (we0 && waddr0 != 0) mem[waddr0] = wdata0;
      if (we1 && waddr1 != 0) mem[waddr1] = wdata1;
      if (flush) begin
        for (int i = 0; i < N; i++) bsy[i] = 1'b0;
      end else begin
        if (we0) bsy[waddr0] = 1'b0;
        if (we1) bsy[waddr1] = 1'b0;
        if (lock_en) bsy[lock_addr] = 1'b1;
      end
      bsy[0] = 1'b0;
    end
  endtask

  task automatic idle();
    reset = 1'b0; we0 = 1'b0; we1 = 1'b0; lock_en = 1'b0; flush = 1'b0;
    raddr1 = '0; raddr2 = '0; waddr0 = '0; waddr1 = '0; lock_addr = '0;
    wdata0 = '0; wdata1 = '0;
  endtask

  task automatic step();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    model_edge();
    @(negedge clk);
    reset = 1'b0;

    // reset clears data; zero register
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1234; step();
    idle(); reset = 1'b1; step();
    idle(); raddr1 = 5'd5;
    #1 chk("reset_rdata1", 64'(rdata1_b), 64'h0);
    chk("reset_rbusy1", 64'(rbusy1_b), 64'h0);
    chk("reset_busy_cnt", 64'(busy_cnt_b), 64'h0);
    step();
    idle(); we0 = 1'b1; waddr0 = '0; wdata0 = 32'hFFFF_FFFF; raddr1 = '0;
    #1 chk("x0_bypass_read", 64'(rdata1_b), 64'h0);
    step();
    idle(); raddr1 = '0;
    #1 chk("x0_after_write", 64'(rdata1_b), 64'h0);
    step();

    // dual write collision
    idle(); we0 = 1'b1; we1 = 1'b1; waddr0 = 5'd7; waddr1 = 5'd7;
    wdata0 = 32'hAAAA; wdata1 = 32'h5555; step();
    idle(); raddr2 = 5'd7;
    #1 chk("collision_byp", 64'(rdata2_b), 64'h5555);
    chk("collision_nobyp", 64'(rdata2_n), 64'h5555);
    step();

    // bypass versus stored value
    idle(); we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h10; step();
    idle(); we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h20; raddr1 = 5'd3;
    #1 chk("bypass_same_cycle", 64'(rdata1_b), 64'h20);
    chk("nobypass_same_cycle", 64'(rdata1_n), 64'h10);
    step();
    idle(); raddr1 = 5'd3;
    #1 chk("nobypass_next_cycle", 64'(rdata1_n), 64'h20);
    step();

    // lock then writeback
    idle(); lock_en = 1'b1; lock_addr = 5'd9; raddr1 = 5'd9; step();
    idle(); raddr1 = 5'd9;
    #1 chk("lock_rbusy1", 64'(rbusy1_b), 64'h1);
    chk("lock_busy_cnt", 64'(busy_cnt_b), 64'h1);
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h99;
    #1 chk("unlock_bypass_rbusy1", 64'(rbusy1_b), 64'h0);
    chk("unlock_nobypass_rbusy1", 64'(rbusy1_n), 64'h1);
    step();
    idle(); raddr1 = 5'd9;
    #1 chk("unlock_busy_cnt", 64'(busy_cnt_b), 64'h0);
    step();

    // lock and clear race on the same register
    idle(); lock_en = 1'b1; lock_addr = 5'd4; step();
    idle(); we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h44; lock_en = 1'b1; lock_addr = 5'd4; step();
    idle(); raddr1 = 5'd4;
    #1 chk("race_rbusy1", 64'(rbusy1_b), 64'h1);
    chk("race_busy_cnt", 64'(busy_cnt_b), 64'h1);
    step();
    idle(); we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h45; step();

    // flush with a simultaneous lock
    for (int r = 1; r <= 3; r++) begin
      idle(); lock_en = 1'b1; lock_addr = AW'(r); step();
    end
    idle();
    #1 chk("pre_flush_busy_cnt", 64'(busy_cnt_b), 64'h3);
    flush = 1'b1; lock_en = 1'b1; lock_addr = 5'd6; step();
    idle(); raddr1 = 5'd6; raddr2 = 5'd3;
    #1 chk("flush_rbusy1", 64'(rbusy1_b), 64'h0);
    chk("flush_rbusy2", 64'(rbusy2_b), 64'h0);
    chk("flush_busy_cnt", 64'(busy_cnt_b), 64'h0);
    chk("flush_data_kept", 64'(rdata2_b), 64'h20);
    step();

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      idle();
      reset     = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      lock_en   = ($urandom_range(0, 1) == 1);
      we0       = ($urandom_range(0, 2) == 0);
      we1       = ($urandom_range(0, 2) == 0);
      lock_addr = AW'($urandom_range(0, 11));
      waddr0    = AW'($urandom_range(0, 11));
      waddr1    = AW'($urandom_range(0, 11));
      raddr1    = AW'($urandom_range(0, 11));
      raddr2    = AW'($urandom_range(0, 31));
      wdata0    = $urandom;
      wdata1    = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_2w2r_sb.md
Name: regfile_2w2r_sb

Overview:
- Parametrised successor to the CPU's 32x32 register file.
- Provides 2 combinational read ports and 2 synchronous write ports for dual writeback.
- Adds optional write-to-read bypass and a per-register busy scoreboard for decode-stage hazard detection.
- Sits between decode (reads, locks) and writeback (writes, unlocks).

Parameters:
- DATA_W, 32, register data width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- raddr1  input  ADDR_W  read port 1 address
- rdata1  output  DATA_W  read port 1 data (combinational)
- rbusy1  output  1  register at raddr1 has a pending write
- raddr2  input  ADDR_W  read port 2 address
- rdata2  output  DATA_W  read port 2 data (combinational)
- rbusy2  output  1  register at raddr2 has a pending write
- we0  input  1  write port 0 enable
- waddr0  input  ADDR_W  write port 0 address
- wdata0  input  DATA_W  write port 0 data
- we1  input  1  write port 1 enable, higher priority than port 0
- waddr1  input  ADDR_W  write port 1 address
- wdata1  input  DATA_W  write port 1 data
- lock_en  input  1  mark lock_addr busy (producer issued)
- lock_addr  input  ADDR_W  register to mark busy
- flush  input  1  clear all busy bits (pipeline flush)
- busy_cnt  output  ADDR_W+1  number of registers currently busy (registered)

Behaviour:
- Reset (clk edge with reset=1):
  - all registers <= 0, all busy bits <= 0, busy_cnt <= 0.
  - reset overrides every write, lock and flush in the same cycle.
- Write:
  - on clk edge, if weN, rf[waddrN] <= wdataN.
  - both ports targeting the same address: port 1 data is stored.
  - ZERO_REG=1: writes to address 0 are discarded.
- Read (combinational, zero latency):
  - ZERO_REG=1 and raddr==0: rdata = 0.
  - BYPASS=1 and we1 && waddr1==raddr: rdata = wdata1.
  - BYPASS=1 and we0 && waddr0==raddr: rdata = wdata0.
  - otherwise rdata = rf[raddr].
  - priority is in the order listed.
  - BYPASS=0: rdata = stored value; a write becomes visible the cycle after the edge.
- Scoreboard, per register:
  - next busy = (busy & ~clear) | set.
  - clear = (we0 && waddr0==r) || (we1 && waddr1==r).
  - set = lock_en && lock_addr==r.
  - lock and clear on the same register in the same cycle: set wins, because a new producer supersedes the old one.
  - flush=1: all busy bits <= 0, and a simultaneous lock_en is also dropped.
  - ZERO_REG=1: busy[0] is held at 0.
  - locking an already-busy register: stays busy, no error.
- rbusyN:
  - = busy[raddrN] && !(BYPASS && a write this cycle hits raddrN).
  - forced 0 for address 0 when ZERO_REG=1.
  - a lock becomes visible on rbusy the cycle after lock_en.
- busy_cnt:
  - registered population count of the busy vector, updated on the same edge as the busy bits.
  - range 0..2**ADDR_W.
- No combinational path from lock_en or flush to any output.

Test Plan:
- Reset and zero register:
  - assert reset 1 cycle after writing x5 = 0x1234.
  - then raddr1=5 -> rdata1=0, rbusy1=0, busy_cnt=0.
  - write x0 = 0xFFFF_FFFF -> rdata1 with raddr1=0 reads 0.
- Dual write collision:
  - we0=we1=1, waddr0=waddr1=7, wdata0=0xAAAA, wdata1=0x5555.
  - next cycle raddr2=7 -> rdata2=0x5555.
- Bypass:
  - x3 holds 0x10; in the same cycle we0=1, waddr0=3, wdata0=0x20, raddr1=3 -> rdata1=0x20 combinationally.
  - with BYPASS=0 the same stimulus -> rdata1=0x10, then 0x20 the next cycle.
- Lock/unlock:
  - lock_en, lock_addr=9 -> next cycle rbusy1(raddr1=9)=1, busy_cnt=1.
  - writeback we1, waddr1=9 -> rbusy1=0 in that cycle (bypass), busy_cnt=0 after the edge.
- Lock/clear race:
  - x4 busy; same cycle we0, waddr0=4 and lock_en, lock_addr=4 -> x4 remains busy, busy_cnt unchanged at 1.
- Flush:
  - lock x1, x2, x3 over 3 cycles (busy_cnt=3).
  - then flush=1 with lock_en, lock_addr=6 -> all rbusy=0 and busy_cnt=0 next cycle; register data unchanged.
